buffer_window_reader: RTL and testbench

Read-side sequencer for the 16-entry signed 8-bit CNN line buffer. On `start` it walks the buffer's read port through a sequence of overlapping convolution windows and streams each tap to the downstream PE over a valid/ready handshake. It sits between the `buffer` read port (`rdb_addr` → `data_out`) and the MAC/PE input. The write side of the buffer is owned by the input loader and is not touched here.

---
 rtl/cnn_buf_pkg.sv | 17 +
 rtl/buffer_window_reader_if.sv | 29 ++
 rtl/buffer_window_reader_addr_gen.sv | 58 +++++
 rtl/buffer_window_reader.sv | 112 +++++++++++
 tb/tb_buffer_window_reader.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_buf_pkg.sv
// Shared widths and read-sequencer state type for the CNN line buffer.
// The buffer module imports the same width constants.
package cnn_buf_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int BUF_DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    HOLD,
    FIN
  } rd_state_t;

endpackage

// File: rtl/buffer_window_reader_if.sv
// Control, buffer read port and tap stream of the window reader.
// The slave modport is the reader's view; master is the surrounding logic.
interface buffer_window_reader_if;
  import cnn_buf_pkg::*;

  logic                     start;
  logic [ADDR_W-1:0]        base_addr;
  logic [ADDR_W-1:0]        num_windows;
  logic [ADDR_W-1:0]        rdb_addr;
  logic signed [DATA_W-1:0] buf_data;
  logic signed [DATA_W-1:0] win_data;
  logic [ADDR_W-1:0]        win_tap;
  logic                     win_last;
  logic                     win_valid;
  logic                     win_ready;
  logic                     busy;
  logic                     done;

  modport slave (
    input  start, base_addr, num_windows, buf_data, win_ready,
    output rdb_addr, win_data, win_tap, win_last, win_valid, busy, done
  );

  modport master (
    output start, base_addr, num_windows, buf_data, win_ready,
    input  rdb_addr, win_data, win_tap, win_last, win_valid, busy, done
  );

endinterface

// File: rtl/buffer_window_reader_addr_gen.sv
// Window/tap counters for the read sequencer; produces the registered
// buffer read address for the current (window, tap) pair.
module window_addr_gen
  import cnn_buf_pkg::*;
#(
  parameter int KERNEL = 3,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] num,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] k,
  output logic              last_tap,
  output logic              last_all
);

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(KERNEL - 1);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(STRIDE);

  logic [ADDR_W-1:0] win_start;
  logic [ADDR_W-1:0] w;
  logic [ADDR_W-1:0] num_q;

  // Address arithmetic wraps modulo the buffer depth by truncation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_start <= '0;
      addr      <= '0;
      k         <= '0;
      w         <= '0;
      num_q     <= '0;
    end else if (load) begin
      win_start <= base;
      addr      <= base;
      k         <= '0;
      w         <= '0;
      num_q     <= num;
    end else if (advance) begin
      if (last_tap) begin
        k         <= '0;
        w         <= w + 1'b1;
        win_start <= win_start + STEP;
        addr      <= win_start + STEP;
      end else begin
        k    <= k + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end

  assign last_tap = (k == K_LAST);
  assign last_all = last_tap && (w == num_q - 1'b1);

endmodule

// File: rtl/buffer_window_reader.sv
// Read-side sequencer: walks the line buffer through overlapping windows
// and streams each tap downstream over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; base/num captured on accept
// RD    | rdb_addr presented for the current (w,k)
// CAP   | buffer data returned, registered into win_data
// HOLD  | win_valid high, outputs frozen until handshake
// FIN   | done pulse, busy low, back to IDLE
module buffer_window_reader
  import cnn_buf_pkg::*;
#(
  parameter int KERNEL = 3,
  parameter int STRIDE = 1
) (
  input logic                   clk,
  input logic                   reset,
  buffer_window_reader_if.slave bus
);

  rd_state_t                state;
  logic                     load;
  logic                     advance;
  logic [ADDR_W-1:0]        gen_addr;
  logic [ADDR_W-1:0]        gen_k;
  logic                     last_tap;
  logic                     last_all;
  logic signed [DATA_W-1:0] win_data_q;
  logic [ADDR_W-1:0]        win_tap_q;
  logic                     win_last_q;
  logic                     win_valid_q;
  logic                     busy_q;
  logic                     done_q;

  assign load    = (state == IDLE) && bus.start && (bus.num_windows != '0);
  // The final handshake leaves the counters alone so rdb_addr keeps its last value.
  assign advance = (state == HOLD) && bus.win_ready && !last_all;

  window_addr_gen #(
    .KERNEL (KERNEL),
    .STRIDE (STRIDE)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .advance  (advance),
    .base     (bus.base_addr),
    .num      (bus.num_windows),
    .addr     (gen_addr),
    .k        (gen_k),
    .last_tap (last_tap),
    .last_all (last_all)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      win_data_q  <= '0;
      win_tap_q   <= '0;
      win_last_q  <= 1'b0;
      win_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_windows == '0) begin
              state  <= FIN;
              done_q <= 1'b1;
            end else begin
              state  <= RD;
              busy_q <= 1'b1;
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          win_data_q  <= bus.buf_data;
          win_tap_q   <= gen_k;
          win_last_q  <= last_tap;
          win_valid_q <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (bus.win_ready) begin
            win_valid_q <= 1'b0;
            if (last_all) begin
              state  <= FIN;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdb_addr  = gen_addr;
  assign bus.win_data  = win_data_q;
  assign bus.win_tap   = win_tap_q;
  assign bus.win_last  = win_last_q;
  assign bus.win_valid = win_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_buffer_window_reader.sv
// Self-checking bench for buffer_window_reader: directed table plus random
// passes against a window/tap address model, on STRIDE=1 and STRIDE=2 instances.
module tb_buffer_window_reader;
  import cnn_buf_pkg::*;

  localparam int KERNEL = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  buffer_window_reader_if bus1 ();
  buffer_window_reader_if bus2 ();

  buffer_window_reader #(.KERNEL(KERNEL), .STRIDE(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  buffer_window_reader #(.KERNEL(KERNEL), .STRIDE(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  // Buffer preloaded with addr i -> i+1, one-cycle read latency.
  logic signed [DATA_W-1:0] mem [BUF_DEPTH];
  initial for (int i = 0; i < BUF_DEPTH; i++) mem[i] = DATA_W'(i + 1);

  always @(posedge clk) begin
    bus1.buf_data <= mem[bus1.rdb_addr];
    bus2.buf_data <= mem[bus2.rdb_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic get_out(input int sel, output int v, output int data, output int tap,
                         output int last, output int busy, output int done, output int addr);
    if (sel == 0) begin
      v = int'(bus1.win_valid); data = int'(bus1.win_data); tap = int'(bus1.win_tap);
      last = int'(bus1.win_last); busy = int'(bus1.busy); done = int'(bus1.done);
      addr = int'(bus1.rdb_addr);
    end else begin
      v = int'(bus2.win_valid); data = int'(bus2.win_data); tap = int'(bus2.win_tap);
      last = int'(bus2.win_last); busy = int'(bus2.busy); done = int'(bus2.done);
      addr = int'(bus2.rdb_addr);
    end
  endtask

  task automatic set_start(input int sel, input logic s, input int base, input int num);
    if (sel == 0) begin
      bus1.start = s; bus1.base_addr = ADDR_W'(base); bus1.num_windows = ADDR_W'(num);
    end else begin
      bus2.start = s; bus2.base_addr = ADDR_W'(base); bus2.num_windows = ADDR_W'(num);
    end
  endtask

  task automatic set_ready(input int sel, input logic r);
    if (sel == 0) bus1.win_ready = r;
    else          bus2.win_ready = r;
  endtask

  task automatic check_zero(input int sel, input string tag);
    int v, data, tap, last, busy, done, addr;
    get_out(sel, v, data, tap, last, busy, done, addr);
    check({tag, "_valid"}, v, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_tap"}, tap, 0);
    check({tag, "_last"}, last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_addr"}, addr, 0);
  endtask

  // mode 0: ready high except stall_cyc cycles on tap stall_tap; mode 1: random ready.
  task automatic run_pass(input int sel, input int base, input int num, input int stride,
                          input int mode, input int stall_tap, input int stall_cyc,
                          input int extra, input string tag,
                          output int sum, output int first, output int lastd, output int ntaps);
    int v, data, tap, last, busy, done, addr;
    int total, idx, hs_cyc, done_cyc, first_valid, stall_cnt;
    int pdata, ptap, plast, ew, ek, eaddr;
    logic rdy, prev_hold;
    total = num * KERNEL;
    idx = 0; hs_cyc = -1; done_cyc = -1; first_valid = -1; stall_cnt = 0;
    sum = 0; first = 0; lastd = 0; prev_hold = 1'b0;
    pdata = 0; ptap = 0; plast = 0;
    set_start(sel, 1'b1, base, num);
    set_ready(sel, 1'b0);
    @(posedge clk); #1;
    set_start(sel, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
      get_out(sel, v, data, tap, last, busy, done, addr);
      if (cyc == 0) begin
        check({tag, "_busy_after_start"}, busy, (num != 0) ? 1 : 0);
        if (num != 0) check({tag, "_first_rdb_addr"}, addr, base);
      end
      if (v != 0 && first_valid < 0) first_valid = cyc;
      if (prev_hold) begin
        check({tag, "_hold_valid"}, v, 1);
        check({tag, "_hold_data"}, data, pdata);
        check({tag, "_hold_tap"}, tap, ptap);
        check({tag, "_hold_last"}, last, plast);
      end
      if (done != 0) begin
        done_cyc = cyc;
        check({tag, "_done_after_last_hs"}, cyc, hs_cyc + 1);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_taps_at_done"}, idx, total);
      end
      rdy = 1'b0;
      if (v != 0) begin
        if (mode == 1) rdy = 1'($urandom_range(0, 1));
        else if (idx == stall_tap && stall_cnt < stall_cyc) stall_cnt++;
        else rdy = 1'b1;
        if (rdy) begin
          if (idx < total) begin
            ew = idx / KERNEL;
            ek = idx % KERNEL;
            eaddr = (base + ew * stride + ek) % BUF_DEPTH;
            check($sformatf("%s_tap%0d_data", tag, idx), data, eaddr + 1);
            check($sformatf("%s_tap%0d_index", tag, idx), tap, ek);
            check($sformatf("%s_tap%0d_last", tag, idx), last, (ek == KERNEL - 1) ? 1 : 0);
          end else begin
            check({tag, "_extra_tap"}, idx + 1, total);
          end
          sum += data;
          if (idx == 0) first = data;
          lastd = data;
          idx++;
          hs_cyc = cyc;
        end
        prev_hold = !rdy;
        pdata = data; ptap = tap; plast = last;
      end else begin
        prev_hold = 1'b0;
      end
      if (extra != 0 && cyc == 4) set_start(sel, 1'b1, 9, 5);
      else set_start(sel, 1'b0, 9, 5);
      set_ready(sel, rdy);
      @(posedge clk); #1;
    end
    set_start(sel, 1'b0, 0, 0);
    set_ready(sel, 1'b0);
    check({tag, "_done_seen"}, (done_cyc >= 0) ? 1 : 0, 1);
    check({tag, "_first_valid_cycle"}, first_valid, (num == 0) ? -1 : 2);
    get_out(sel, v, data, tap, last, busy, done, addr);
    check({tag, "_done_width"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    ntaps = idx;
  endtask

  typedef struct {
    int sel;
    int base;
    int num;
    int stride;
    int stall_tap;
    int stall_cyc;
    int extra;
    int exp_taps;
    int exp_sum;
    int exp_first;
    int exp_last;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum, first, lastd, ntaps;
    int v, data, tap, last, busy, done, addr, hs, hit;
    logic r;

    //          sel base num str stall_tap cyc extra taps sum first last
    vecs[0] = '{0,  0,   2,  1,  -1,       0,  0,    6,   15,  1,    4};
    vecs[1] = '{0,  14,  2,  1,  -1,       0,  0,    6,   51,  15,   2};
    vecs[2] = '{0,  0,   2,  1,  1,        5,  0,    6,   15,  1,    4};
    vecs[3] = '{0,  5,   0,  1,  -1,       0,  0,    0,   0,   0,    0};
    vecs[4] = '{0,  0,   2,  1,  -1,       0,  1,    6,   15,  1,    4};
    vecs[5] = '{1,  0,   3,  2,  -1,       0,  0,    9,   36,  1,    7};

    reset = 1'b1;
    set_start(0, 1'b0, 0, 0); set_start(1, 1'b0, 0, 0);
    set_ready(0, 1'b0); set_ready(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_zero(0, "reset1");
    check_zero(1, "reset2");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_pass(vecs[i].sel, vecs[i].base, vecs[i].num, vecs[i].stride, 0,
               vecs[i].stall_tap, vecs[i].stall_cyc, vecs[i].extra,
               $sformatf("v%0d", i), sum, first, lastd, ntaps);
      check($sformatf("v%0d_ntaps", i), ntaps, vecs[i].exp_taps);
      check($sformatf("v%0d_sum", i), sum, vecs[i].exp_sum);
      if (vecs[i].exp_taps > 0) begin
        check($sformatf("v%0d_first", i), first, vecs[i].exp_first);
        check($sformatf("v%0d_lastdata", i), lastd, vecs[i].exp_last);
      end
      repeat (2) @(posedge clk);
      #1;
    end

    // Reset in window 1 HOLD, then a fresh pass.
    set_start(0, 1'b1, 0, 2);
    @(posedge clk); #1;
    set_start(0, 1'b0, 0, 2);
    hs = 0; hit = 0;
    for (int c = 0; c < 100 && hit == 0; c++) begin
      get_out(0, v, data, tap, last, busy, done, addr);
      if (v != 0 && hs == 3) begin
        hit = 1;
      end else begin
        r = (v != 0);
        if (r) hs++;
        set_ready(0, r);
        @(posedge clk); #1;
      end
    end
    check("rst_reached_w1_hold", hit, 1);
    check("rst_w1_data_before", data, 2);
    reset = 1'b1;
    #1;
    check_zero(0, "midpass_reset");
    set_ready(0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      get_out(0, v, data, tap, last, busy, done, addr);
      check("abandoned_no_done", done, 0);
      check("abandoned_no_valid", v, 0);
    end
    run_pass(0, 4, 1, 1, 0, -1, 0, 0, "post_rst", sum, first, lastd, ntaps);
    check("post_rst_ntaps", ntaps, 3);
    check("post_rst_sum", sum, 18);
    check("post_rst_first", first, 5);
    check("post_rst_last", lastd, 7);

    // Random passes on both strides with random back-pressure.
    for (int i = 0; i < 24; i++) begin
      int sel, base, num, mode, stl, scy, ext;
      sel  = int'($urandom_range(0, 1));
      base = int'($urandom_range(0, 15));
      num  = int'($urandom_range(0, 4));
      mode = int'($urandom_range(0, 1));
      stl  = int'($urandom_range(0, 12));
      scy  = int'($urandom_range(0, 4));
      ext  = int'($urandom_range(0, 1));
      run_pass(sel, base, num, sel + 1, mode, stl, scy, ext,
               $sformatf("rnd%0d", i), sum, first, lastd, ntaps);
      check($sformatf("rnd%0d_ntaps", i), ntaps, num * KERNEL);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
